// File: rtl/freq_divider_mc.sv
// freq_divider_mc: multi-channel programmable event divider, one output event per N+1 input ticks
// Ports: clk; sta_user = synchronous active-high reset
//        tick_in/en/restart/mode = per-channel event strobe, enable, restart, output mode (1 = toggle)
//        div_wr/div_ch/div_val = write a new shadow N into one channel
//        pulse_out/level_out = per-channel boundary strobe and pulse/square level
//        div_active = active N per channel, channel k at [k*CW +: CW]
module freq_divider_mc #(
    parameter int NCH = 4,
    parameter int CW = 32,
    parameter int DEFAULT_DIV = 10
) (
    input  logic              clk,
    input  logic              sta_user,
    input  logic [NCH-1:0]    tick_in,
    input  logic [NCH-1:0]    en,
    input  logic [NCH-1:0]    restart,
    input  logic [NCH-1:0]    mode,
    input  logic              div_wr,
    input  logic [3:0]        div_ch,
    input  logic [CW-1:0]     div_val,
    output logic [NCH-1:0]    pulse_out,
    output logic [NCH-1:0]    level_out,
    output logic [NCH*CW-1:0] div_active
);
    localparam logic [CW-1:0] DEF = CW'(DEFAULT_DIV);
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [CW-1:0] cnt, shadow, active, shadow_nx;
        logic pulse, level, wr;
        assign wr = div_wr && div_ch == 4'(k);
        // a write landing in the same clk as a copy is forwarded, so the copy takes the new value
        assign shadow_nx = wr ? div_val : shadow;
        always_ff @(posedge clk) begin
            if (sta_user) begin
                cnt <= '0;
                shadow <= DEF;
                active <= DEF;
                pulse <= 1'b0;
                level <= 1'b0;
            end else begin
                shadow <= shadow_nx;
                if (restart[k]) begin
                    cnt <= '0;
                    pulse <= 1'b0;
                    level <= 1'b0;
                    active <= shadow_nx;
                end else if (!en[k]) begin
                    pulse <= 1'b0;
                    active <= shadow_nx;
                end else if (tick_in[k] && cnt >= active) begin
                    // >= so a divide value lowered below cnt wraps on the next tick
                    cnt <= '0;
                    pulse <= 1'b1;
                    level <= mode[k] ? ~level : 1'b1;
                    active <= shadow_nx;
                end else begin
                    cnt <= tick_in[k] ? cnt + 1'b1 : cnt;
                    pulse <= 1'b0;
                    level <= mode[k] & level;
                end
            end
        end
        assign pulse_out[k] = pulse;
        assign level_out[k] = level;
        assign div_active[k*CW +: CW] = active;
    end
endmodule

// File: tb/tb_freq_divider_mc.sv
// tb_freq_divider_mc: table/sequence driven scoreboard bench for freq_divider_mc
module tb_freq_divider_mc;
    localparam int NCH = 4;
    localparam int CW = 32;
    logic clk = 1'b0;
    logic sta_user = 1'b1;
    logic [NCH-1:0] tick_in = '0, en = '0, restart = '0, mode = '0;
    logic div_wr = 1'b0;
    logic [3:0] div_ch = '0;
    logic [CW-1:0] div_val = '0;
    logic [NCH-1:0] pulse_out, level_out;
    logic [NCH*CW-1:0] div_active;
    int checks = 0, fails = 0, np = 0, nt = 0;
    logic prev_l, b;

    typedef struct { logic [3:0] ep, el; string name; } exp_t;
    typedef struct {
        logic [3:0] tick, en, rs, md;
        logic wr;
        logic [3:0] ch;
        logic [31:0] val;
        logic [3:0] ep, el;
    } vec_t;
    exp_t sb[$];
    vec_t tbl[$];

    freq_divider_mc #(.NCH(NCH), .CW(CW), .DEFAULT_DIV(10)) dut (
        .clk(clk), .sta_user(sta_user), .tick_in(tick_in), .en(en), .restart(restart),
        .mode(mode), .div_wr(div_wr), .div_ch(div_ch), .div_val(div_val),
        .pulse_out(pulse_out), .level_out(level_out), .div_active(div_active)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic [3:0] tick, logic [3:0] e, logic [3:0] rs, logic [3:0] md,
                                logic wr, logic [3:0] ch, logic [31:0] val,
                                logic [3:0] ep, logic [3:0] el);
        vec_t v;
        v.tick = tick; v.en = e; v.rs = rs; v.md = md; v.wr = wr;
        v.ch = ch; v.val = val; v.ep = ep; v.el = el;
        return v;
    endfunction

    task automatic step(input vec_t v, input string name);
        exp_t e;
        tick_in = v.tick; en = v.en; restart = v.rs; mode = v.md;
        div_wr = v.wr; div_ch = v.ch; div_val = v.val;
        e.ep = v.ep; e.el = v.el; e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (pulse_out !== e.ep || level_out !== e.el) begin
            fails++;
            $display("FAIL %s @%0t: pulse_out=%b level_out=%b, expected pulse_out=%b level_out=%b",
                     e.name, $time, pulse_out, level_out, e.ep, e.el);
        end
    endtask

    task automatic chk_div(input int k, input logic [CW-1:0] exp, input string name);
        checks++;
        if (div_active[k*CW +: CW] !== exp) begin
            fails++;
            $display("FAIL %s div_active[%0d]: got %0d, expected %0d", name, k, div_active[k*CW +: CW], exp);
        end
    endtask

    task automatic do_reset(input logic wr, input logic [3:0] ch, input logic [31:0] val);
        sta_user = 1'b1;
        step(mk(4'hF, 4'hF, 4'h0, 4'hF, wr, ch, val, 4'h0, 4'h0), "reset_outputs");
        sta_user = 1'b0;
        for (int k = 0; k < NCH; k++) chk_div(k, 10, "reset_div");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // 1: default divide by 11 on ch0, others enabled but silent
        do_reset(1'b0, 4'd0, 32'd0);
        for (int i = 1; i <= 33; i++)
            step(mk(4'b0001, 4'b1111, 4'h0, 4'h0, 1'b0, 4'd0, 32'd0,
                    {3'b0, i % 11 == 0}, {3'b0, i % 11 == 0}), "t1_div11");

        // 2: ch1 N=3 toggle mode, 40 ticks
        do_reset(1'b0, 4'd0, 32'd0);
        step(mk(4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 4'd1, 32'd3, 4'h0, 4'h0), "t2_wr");
        step(mk(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'd0, 32'd0, 4'h0, 4'h0), "t2_idle");
        chk_div(1, 3, "t2_div");
        prev_l = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            step(mk(4'b0010, 4'b0010, 4'h0, 4'b0010, 1'b0, 4'd0, 32'd0,
                    {2'b0, i % 4 == 0, 1'b0}, {2'b0, (i / 4) % 2 == 1, 1'b0}), "t2_toggle");
            np += int'(pulse_out[1]);
            nt += int'(level_out[1] != prev_l);
            prev_l = level_out[1];
        end
        checks++;
        if (np != 10 || nt != 10) begin
            fails++;
            $display("FAIL t2_counts: pulses=%0d toggles=%0d, expected 10 and 10", np, nt);
        end

        // 3: mid-period write does not cut the period; write+wrap takes the new value
        do_reset(1'b0, 4'd0, 32'd0);
        for (int t = 1; t <= 5; t++)
            step(mk(4'b0001, 4'b0001, 4'h0, 4'h0, 1'b0, 4'd0, 32'd0, 4'h0, 4'h0), "t3_pre");
        step(mk(4'h0, 4'b0001, 4'h0, 4'h0, 1'b1, 4'd0, 32'd7, 4'h0, 4'h0), "t3_wr_mid");
        for (int t = 6; t <= 20; t++)
            step(mk(4'b0001, 4'b0001, 4'h0, 4'h0, t == 11, 4'd0, 32'd2,
                    {3'b0, t == 11 || (t > 11 && (t - 11) % 3 == 0)},
                    {3'b0, t == 11 || (t > 11 && (t - 11) % 3 == 0)}), "t3_post");
        chk_div(0, 2, "t3_div");

        // 4: N=0 on ch2 mirrors sparse ticks one clk later
        do_reset(1'b0, 4'd0, 32'd0);
        step(mk(4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 4'd2, 32'd0, 4'h0, 4'h0), "t4_wr");
        step(mk(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'd0, 32'd0, 4'h0, 4'h0), "t4_idle");
        chk_div(2, 0, "t4_div");
        for (int i = 0; i < 30; i++) begin
            b = ($urandom_range(0, 2) == 0);
            step(mk({1'b0, b, 2'b0}, 4'b0100, 4'h0, 4'h0, 1'b0, 4'd0, 32'd0,
                    {1'b0, b, 2'b0}, {1'b0, b, 2'b0}), "t4_mirror");
        end

        // 5: enable freeze, pending shadow, mode switches, restart (table driven)
        do_reset(1'b0, 4'd0, 32'd0);
        tbl.delete();
        repeat (4) tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 5, 0, 0));
        repeat (7) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 1));
        repeat (5) tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 1, 0));
        repeat (5) tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 1, 1));
        repeat (2) tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 0));
        repeat (5) tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("t5_vec%0d", i));
        chk_div(0, 5, "t5_div");

        // safety: N lowered below cnt wraps on the next tick (ch3)
        do_reset(1'b0, 4'd0, 32'd0);
        repeat (6) step(mk(4'b1000, 4'b1000, 4'h0, 4'h0, 1'b0, 4'd0, 32'd0, 4'h0, 4'h0), "ts_pre");
        step(mk(4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 4'd3, 32'd2, 4'h0, 4'h0), "ts_wr");
        step(mk(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'd0, 32'd0, 4'h0, 4'h0), "ts_idle");
        chk_div(3, 2, "ts_div");
        step(mk(4'b1000, 4'b1000, 4'h0, 4'h0, 1'b0, 4'd0, 32'd0, 4'b1000, 4'b1000), "ts_wrap");
        repeat (2) step(mk(4'b1000, 4'b1000, 4'h0, 4'h0, 1'b0, 4'd0, 32'd0, 4'h0, 4'h0), "ts_cnt");
        step(mk(4'b1000, 4'b1000, 4'h0, 4'h0, 1'b0, 4'd0, 32'd0, 4'b1000, 4'b1000), "ts_wrap2");

        // 6: reset mid-count with a write (ignored), then out-of-range channel write
        do_reset(1'b0, 4'd0, 32'd0);
        repeat (5) step(mk(4'b0001, 4'b0001, 4'h0, 4'h0, 1'b0, 4'd0, 32'd0, 4'h0, 4'h0), "t6_pre");
        do_reset(1'b1, 4'd0, 32'd3);
        step(mk(4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 4'd7, 32'd1, 4'h0, 4'h0), "t6_wr_oor");
        step(mk(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'd0, 32'd0, 4'h0, 4'h0), "t6_idle");
        for (int k = 0; k < NCH; k++) chk_div(k, 10, "t6_div");
        for (int i = 1; i <= 11; i++)
            step(mk(4'b0001, 4'b0001, 4'h0, 4'h0, 1'b0, 4'd0, 32'd0,
                    {3'b0, i == 11}, {3'b0, i == 11}), "t6_post");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
